// File: rtl/muldiv_wb_arbiter.sv
// Merges multiplier results (small FIFO) and divider results (one holding register) onto one
// write-back port, with starvation-bounded priority. Optional macro: MULDIV_WB_PC_TRACK_EN adds pc tracking.
module muldiv_wb_arbiter #(
    parameter int unsigned TRANS_ID_BITS  = 3,
    parameter int unsigned XLEN           = 64,
    parameter int unsigned VLEN           = 64,
    parameter int unsigned MUL_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     mul_valid_i,
    input  logic [XLEN-1:0]          mul_result_i,
    input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i,
    output logic                     mul_ready_o,
    input  logic                     div_valid_i,
    input  logic [XLEN-1:0]          div_result_i,
    input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
    output logic                     div_ready_o,
    output logic                     wb_valid_o,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    input  logic                     wb_ready_i,
`ifdef MULDIV_WB_PC_TRACK_EN
    input  logic [VLEN-1:0]          mul_pc_i,
    input  logic [VLEN-1:0]          div_pc_i,
    output logic [VLEN-1:0]          wb_pc_o,
`endif
    output logic                     mul_overflow_o
);

    localparam int unsigned PTR_W = (MUL_FIFO_DEPTH > 1) ? $clog2(MUL_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MUL_FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {PRIO_MUL = 1'b0, PRIO_DIV = 1'b1} arb_state_e;

    logic [XLEN-1:0]          mem_result_r [MUL_FIFO_DEPTH];
    logic [TRANS_ID_BITS-1:0] mem_id_r     [MUL_FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]         count_r;
    logic [CNT_W:0]           occ_s;
    logic                     hold_valid_r;
    logic [XLEN-1:0]          hold_result_r;
    logic [TRANS_ID_BITS-1:0] hold_id_r;
    logic [STV_W-1:0]         starve_r, starve_next_s;
    arb_state_e               state_r, state_next_s;
    logic                     lock_valid_r, lock_div_r;
    logic                     overflow_r;
    logic                     fifo_empty_s, fifo_full_s;
    logic                     sel_div_s, wb_valid_s, wb_fire_s;
    logic                     mul_pop_s, div_pop_s, mul_push_s, mul_drop_s, div_capture_s;
`ifdef MULDIV_WB_PC_TRACK_EN
    logic [VLEN-1:0]          mem_pc_r [MUL_FIFO_DEPTH];
    logic [VLEN-1:0]          hold_pc_r;
`endif

    assign fifo_empty_s  = (count_r == {CNT_W{1'b0}});
    assign fifo_full_s   = (count_r == DEPTH_C);
    assign wb_valid_s    = ~fifo_empty_s | hold_valid_r;
    assign wb_fire_s     = wb_valid_s & wb_ready_i;
    assign mul_pop_s     = wb_fire_s & ~sel_div_s;
    assign div_pop_s     = wb_fire_s & sel_div_s;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign mul_push_s    = mul_valid_i & ~flush_i & (~fifo_full_s | mul_pop_s);
    assign mul_drop_s    = mul_valid_i & ~flush_i & fifo_full_s & ~mul_pop_s;
    assign div_capture_s = div_valid_i & ~hold_valid_r & ~flush_i;
    assign occ_s         = {1'b0, count_r} + {{CNT_W{1'b0}}, mul_valid_i};
    assign mul_ready_o   = (occ_s < {1'b0, DEPTH_C});
    assign div_ready_o   = ~hold_valid_r;
    assign mul_overflow_o = overflow_r;

    // FIFO storage; contents are only observable through count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (mul_push_s) begin
            mem_result_r[wr_ptr_r] <= mul_result_i;
            mem_id_r[wr_ptr_r]     <= mul_trans_id_i;
`ifdef MULDIV_WB_PC_TRACK_EN
            mem_pc_r[wr_ptr_r]     <= mul_pc_i;
`endif
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (mul_drop_s) begin
                overflow_r <= 1'b1;
            end
            if (flush_i) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (mul_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                if (mul_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                case ({mul_push_s, mul_pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Divider holding register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_valid_r  <= 1'b0;
            hold_result_r <= {XLEN{1'b0}};
            hold_id_r     <= {TRANS_ID_BITS{1'b0}};
`ifdef MULDIV_WB_PC_TRACK_EN
            hold_pc_r     <= {VLEN{1'b0}};
`endif
        end else if (flush_i) begin
            hold_valid_r <= 1'b0;
        end else if (div_capture_s) begin
            hold_valid_r  <= 1'b1;
            hold_result_r <= div_result_i;
            hold_id_r     <= div_trans_id_i;
`ifdef MULDIV_WB_PC_TRACK_EN
            hold_pc_r     <= div_pc_i;
`endif
        end else if (div_pop_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    // Starvation counter next value: counts divider losses while a result is held.
    always_comb begin
        starve_next_s = starve_r;
        if (!hold_valid_r || div_pop_s) begin
            starve_next_s = {STV_W{1'b0}};
        end else if (mul_pop_s && (starve_r != LIMIT_C)) begin
            starve_next_s = starve_r + STV_W'(1);
        end else begin
            starve_next_s = starve_r;
        end
    end

    // State register, starvation counter and stall lock.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_r      <= PRIO_MUL;
            starve_r     <= {STV_W{1'b0}};
            lock_valid_r <= 1'b0;
            lock_div_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            starve_r     <= starve_next_s;
            lock_valid_r <= wb_valid_s & ~wb_ready_i;
            lock_div_r   <= sel_div_s;
        end
    end

    // Next-state: forced divider priority as soon as the loss budget is exhausted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PRIO_MUL: begin
                if (hold_valid_r && !div_pop_s && (starve_next_s == LIMIT_C)) begin
                    state_next_s = PRIO_DIV;
                end else begin
                    state_next_s = PRIO_MUL;
                end
            end
            PRIO_DIV: begin
                if (div_pop_s) begin
                    state_next_s = PRIO_MUL;
                end else begin
                    state_next_s = PRIO_DIV;
                end
            end
            default: state_next_s = PRIO_MUL;
        endcase
    end

    // Output selection; a stalled payload keeps its source even if the FIFO fills meanwhile.
    always_comb begin
        sel_div_s     = 1'b0;
        wb_valid_o    = wb_valid_s;
        wb_result_o   = {XLEN{1'b0}};
        wb_trans_id_o = {TRANS_ID_BITS{1'b0}};
`ifdef MULDIV_WB_PC_TRACK_EN
        wb_pc_o       = {VLEN{1'b0}};
`endif
        if (lock_valid_r) begin
            sel_div_s = lock_div_r;
        end else if (state_r == PRIO_DIV) begin
            sel_div_s = 1'b1;
        end else begin
            sel_div_s = fifo_empty_s;
        end
        if (wb_valid_s && sel_div_s) begin
            wb_result_o   = hold_result_r;
            wb_trans_id_o = hold_id_r;
`ifdef MULDIV_WB_PC_TRACK_EN
            wb_pc_o       = hold_pc_r;
`endif
        end else if (wb_valid_s) begin
            wb_result_o   = mem_result_r[rd_ptr_r];
            wb_trans_id_o = mem_id_r[rd_ptr_r];
`ifdef MULDIV_WB_PC_TRACK_EN
            wb_pc_o       = mem_pc_r[rd_ptr_r];
`endif
        end else begin
            wb_result_o   = {XLEN{1'b0}};
            wb_trans_id_o = {TRANS_ID_BITS{1'b0}};
        end
    end

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Directed self-checking bench for muldiv_wb_arbiter (default configuration, DEPTH=2, STARVE_LIMIT=4).
module tb_muldiv_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i;
    logic        mul_valid_i, div_valid_i, wb_ready_i;
    logic [63:0] mul_result_i, div_result_i;
    logic [2:0]  mul_trans_id_i, div_trans_id_i;
    logic        mul_ready_o, div_ready_o, wb_valid_o, mul_overflow_o;
    logic [63:0] wb_result_o;
    logic [2:0]  wb_trans_id_o;
`ifdef MULDIV_WB_PC_TRACK_EN
    logic [63:0] mul_pc_i = 64'd0;
    logic [63:0] div_pc_i = 64'd0;
    logic [63:0] wb_pc_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    muldiv_wb_arbiter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .mul_valid_i    (mul_valid_i),
        .mul_result_i   (mul_result_i),
        .mul_trans_id_i (mul_trans_id_i),
        .mul_ready_o    (mul_ready_o),
        .div_valid_i    (div_valid_i),
        .div_result_i   (div_result_i),
        .div_trans_id_i (div_trans_id_i),
        .div_ready_o    (div_ready_o),
        .wb_valid_o     (wb_valid_o),
        .wb_result_o    (wb_result_o),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_ready_i     (wb_ready_i),
`ifdef MULDIV_WB_PC_TRACK_EN
        .mul_pc_i       (mul_pc_i),
        .div_pc_i       (div_pc_i),
        .wb_pc_o        (wb_pc_o),
`endif
        .mul_overflow_o (mul_overflow_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are then changed at +2 and outputs sampled at +3.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        mul_valid_i = 1'b0;
        div_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic mul_in(input logic [2:0] id, input logic [63:0] res);
        mul_valid_i    = 1'b1;
        mul_trans_id_i = id;
        mul_result_i   = res;
    endtask

    task automatic div_in(input logic [2:0] id, input logic [63:0] res);
        div_valid_i    = 1'b1;
        div_trans_id_i = id;
        div_result_i   = res;
    endtask

    task automatic wb_expect(input string tag, input logic [2:0] id, input logic [63:0] res);
        chk({tag, "_valid"}, 64'(wb_valid_o), 64'd1);
        chk({tag, "_id"}, 64'(wb_trans_id_o), 64'(id));
        chk({tag, "_res"}, wb_result_o, res);
    endtask

    task automatic wb_expect_empty(input string tag);
        chk({tag, "_valid"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_res"}, wb_result_o, 64'd0);
        chk({tag, "_id"}, 64'(wb_trans_id_o), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1; wb_ready_i = 1'b1;
        mul_result_i = 64'd0; mul_trans_id_i = 3'd0;
        div_result_i = 64'd0; div_trans_id_i = 3'd0;
        idle();
        tick(); tick();
        settle();
        wb_expect_empty("rst");
        chk("rst_div_ready", 64'(div_ready_o), 64'd1);
        chk("rst_mul_ready", 64'(mul_ready_o), 64'd1);
        chk("rst_ovf", 64'(mul_overflow_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // 1: single multiplier result, one-cycle latency
        mul_in(3'd1, 64'h2A); tick(); idle(); settle();
        wb_expect("t1", 3'd1, 64'h2A);
        tick(); settle();
        chk("t1_drained", 64'(wb_valid_o), 64'd0);

        // 2: back-pressure fills FIFO, then drains in order
        wb_ready_i = 1'b0;
        mul_in(3'd1, 64'h11); settle();
        chk("t2_ready_c0", 64'(mul_ready_o), 64'd1);
        tick(); mul_in(3'd2, 64'h22); settle();
        chk("t2_ready_c1", 64'(mul_ready_o), 64'd0);
        tick(); idle(); settle();
        chk("t2_ready_full", 64'(mul_ready_o), 64'd0);
        wb_expect("t2_stall", 3'd1, 64'h11);
        wb_ready_i = 1'b1; settle();
        wb_expect("t2_d1", 3'd1, 64'h11);
        tick(); settle();
        wb_expect("t2_d2", 3'd2, 64'h22);
        chk("t2_ready_after", 64'(mul_ready_o), 64'd1);
        tick(); settle();
        chk("t2_empty", 64'(wb_valid_o), 64'd0);
        chk("t2_ovf", 64'(mul_overflow_o), 64'd0);

        // 3: held divider result wins after 4 multiplier write-backs
        div_in(3'd5, 64'h7); mul_in(3'd0, 64'h100); tick();
        div_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            mul_in(3'(k), 64'h100 + 64'(k)); settle();
            wb_expect($sformatf("t3_mul%0d", k - 1), 3'(k - 1), 64'h100 + 64'(k - 1));
            chk($sformatf("t3_div_busy%0d", k), 64'(div_ready_o), 64'd0);
            tick();
        end
        idle(); settle();
        wb_expect("t3_div", 3'd5, 64'h7);
        chk("t3_div_busy5", 64'(div_ready_o), 64'd0);
        tick(); settle();
        chk("t3_div_ready", 64'(div_ready_o), 64'd1);
        wb_expect("t3_mul4", 3'd4, 64'h104);
        tick(); settle();
        chk("t3_empty", 64'(wb_valid_o), 64'd0);

        // 4: simultaneous arrival, multiplier first
        mul_in(3'd6, 64'h66); div_in(3'd3, 64'h33); tick(); idle(); settle();
        wb_expect("t4_mul", 3'd6, 64'h66);
        tick(); settle();
        wb_expect("t4_div", 3'd3, 64'h33);
        tick(); settle();
        chk("t4_empty", 64'(wb_valid_o), 64'd0);
        chk("t4_div_ready", 64'(div_ready_o), 64'd1);

        // 7: stalled divider payload stays put when a multiplier result arrives
        wb_ready_i = 1'b0;
        div_in(3'd4, 64'h44); tick(); idle(); settle();
        wb_expect("t7_hold", 3'd4, 64'h44);
        mul_in(3'd2, 64'h55); tick(); idle(); settle();
        wb_expect("t7_stable", 3'd4, 64'h44);
        wb_ready_i = 1'b1; tick(); settle();
        wb_expect("t7_mul", 3'd2, 64'h55);
        tick(); settle();
        chk("t7_empty", 64'(wb_valid_o), 64'd0);

        // 5: flush discards everything, drops flush-cycle input
        wb_ready_i = 1'b0;
        mul_in(3'd1, 64'h1); div_in(3'd2, 64'h2); tick();
        div_valid_i = 1'b0; mul_in(3'd3, 64'h3); tick(); idle(); settle();
        chk("t5_pre_valid", 64'(wb_valid_o), 64'd1);
        chk("t5_pre_div_ready", 64'(div_ready_o), 64'd0);
        chk("t5_pre_mul_ready", 64'(mul_ready_o), 64'd0);
        flush_i = 1'b1; mul_in(3'd7, 64'h77); tick(); idle(); settle();
        wb_expect_empty("t5_post");
        chk("t5_div_ready", 64'(div_ready_o), 64'd1);
        chk("t5_mul_ready", 64'(mul_ready_o), 64'd1);
        chk("t5_ovf", 64'(mul_overflow_o), 64'd0);

        // 6: push into full FIFO drops entry and sets sticky overflow
        mul_in(3'd1, 64'hA1); tick();
        mul_in(3'd2, 64'hA2); tick();
        mul_in(3'd3, 64'hA3); tick(); idle(); settle();
        chk("t6_ovf", 64'(mul_overflow_o), 64'd1);
        wb_ready_i = 1'b1; settle();
        wb_expect("t6_d1", 3'd1, 64'hA1);
        tick(); settle();
        wb_expect("t6_d2", 3'd2, 64'hA2);
        tick(); settle();
        chk("t6_dropped", 64'(wb_valid_o), 64'd0);
        flush_i = 1'b1; tick(); idle(); settle();
        chk("t6_ovf_flush", 64'(mul_overflow_o), 64'd1);
        rst_i = 1'b1; tick(); rst_i = 1'b0; settle();
        chk("t6_ovf_rst", 64'(mul_overflow_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
